imm_issue_sequencer: RTL and testbench
======================================

IMM_ISSUE_SEQUENCER -- requirements
Module: imm_issue_sequencer

Interface
REQ-001 Clock, reset and all ports SHALL be exactly as listed in REQ-002..REQ-014.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_instr  input  16  fetched instruction; opcode = [15:11], immediate field = [10:0].
REQ-005 in_valid  input  1  in_instr valid this cycle.
REQ-006 in_ready  output  1  sequencer accepts in_instr this cycle.
REQ-007 flush  input  1  discard held instruction and any pending micro-op.
REQ-008 out_valid  output  1  micro-op presented to immediate datapath.
REQ-009 out_ready  input  1  downstream consumes micro-op this cycle.
REQ-010 out_instr  output  11  registered in_instr[10:0] for the immediate generator.
REQ-011 ImmOp  output  3  immediate select/shift control to the immediate generator.
REQ-012 RegZero  output  1  force immediate output to zero.
REQ-013 uop_seq  output  1  0 = first/only micro-op, 1 = second micro-op of LIW.
REQ-014 illegal  output  1  one-cycle pulse when a reserved-class opcode is accepted.

Function
REQ-015 Transfers SHALL occur only on in_valid&&in_ready (accept) and out_valid&&out_ready (issue).
REQ-016 Class = opcode[4:2]; decode SHALL be: 000 R-type -> ImmOp 000, RegZero 1; 001 imm7 -> 000, 0; 010 imm9 -> 001, 0; 011 branch -> 010, 0; 100 jump -> 011, 0; 101 LUI -> 101, 0; 110 LIW -> two micro-ops; 111 reserved -> ImmOp 000, RegZero 1, illegal pulse.
REQ-017 FSM states SHALL be EMPTY, FULL, LIW_HI, LIW_LO.
REQ-018 EMPTY: out_valid 0; accept -> FULL (LIW_HI for class 110) with outputs registered next cycle (latency 1).
REQ-019 FULL: out_valid 1; issue with simultaneous accept -> reload (FULL or LIW_HI); issue without accept -> EMPTY; no issue -> hold all outputs stable.
REQ-020 LIW_HI: out_valid 1, ImmOp 101, RegZero 0, uop_seq 0; issue -> LIW_LO; in_ready SHALL be 0.
REQ-021 LIW_LO: out_valid 1, ImmOp 000, RegZero 0, uop_seq 1, same out_instr; behaves as FULL for issue/accept.
REQ-022 in_ready SHALL equal !flush && (state==EMPTY || ((state==FULL||state==LIW_LO) && out_ready)).
REQ-023 Outputs SHALL not change while out_valid && !out_ready (stall hold).
REQ-024 flush SHALL take priority over issue and accept: next state EMPTY, out_valid 0, pending LIW_LO dropped, in_instr ignored.
REQ-025 When out_valid is 0, ImmOp SHALL be 000 and RegZero 1.
REQ-026 illegal SHALL assert for exactly the cycle in which the reserved instruction is first presented (out_valid rising with it), never during stall hold.

Reset
REQ-027 While rst_n is 0 at a clock edge: state EMPTY, out_valid 0, out_instr 0, ImmOp 000, RegZero 1, uop_seq 0, illegal 0.
REQ-028 in_ready SHALL be 0 while rst_n is 0; reset SHALL abort any in-progress LIW sequence.

Structure
REQ-029 Opcode-class constants, ImmOp encodings (IMM7, IMM9, IMM7_SH1, IMM9_SH1, IMM_SH7) and FSM state encodings SHALL live in a shared package/include.
REQ-030 One sub-module, imm_class_decode (combinational opcode -> ImmOp/RegZero/is_liw/is_illegal), SHALL be instantiated; sequencer is single-module otherwise.

Verification
REQ-031 Reset, then in_instr 16'h4123 valid, out_ready 1 -> next cycle out_valid 1, out_instr 11'h123, ImmOp 001, RegZero 0, uop_seq 0.
REQ-032 in_instr 16'hC0FF accepted, out_ready 1 -> two issues: ImmOp 101/uop_seq 0 then ImmOp 000/uop_seq 1, out_instr 11'h0FF both; in_ready 0 in LIW_HI cycle.
REQ-033 Back-to-back 16'h2005, 16'h6010 with out_ready 1 -> one issue per cycle, ImmOp 000 then 010, no bubble.
REQ-034 out_ready 0 for 3 cycles with FULL holding 16'h8001 -> outputs stable (ImmOp 011), in_ready 0, no accept.
REQ-035 flush in LIW_HI of 16'hC0FF -> next cycle out_valid 0, ImmOp 000, RegZero 1, no uop_seq 1 issue.
REQ-036 in_instr 16'hF800 accepted -> illegal 1 for one cycle, ImmOp 000, RegZero 1; rst_n 0 mid-sequence -> REQ-027 values next cycle.

Source files
------------

// File: rtl/imm_issue_sequencer_pkg.sv
// Shared types and encodings for the immediate-issue sequencer.
// Holds opcode classes, ImmOp controls, FSM states and the micro-op payload.
package imm_issue_sequencer_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned IMM_W   = 11;
   localparam int unsigned IMMOP_W = 3;
   localparam int unsigned CLASS_W = 3;

   // Opcode class = opcode[4:2]
   typedef enum logic [CLASS_W-1:0] {
      CLS_RTYPE  = 3'b000,
      CLS_IMM7   = 3'b001,
      CLS_IMM9   = 3'b010,
      CLS_BRANCH = 3'b011,
      CLS_JUMP   = 3'b100,
      CLS_LUI    = 3'b101,
      CLS_LIW    = 3'b110,
      CLS_RSVD   = 3'b111
   } op_class_e;

   localparam logic [IMMOP_W-1:0] IMMOP_IMM7     = 3'b000;
   localparam logic [IMMOP_W-1:0] IMMOP_IMM9     = 3'b001;
   localparam logic [IMMOP_W-1:0] IMMOP_IMM7_SH1 = 3'b010;
   localparam logic [IMMOP_W-1:0] IMMOP_IMM9_SH1 = 3'b011;
   localparam logic [IMMOP_W-1:0] IMMOP_IMM_SH7  = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'b00,
      ST_FULL   = 2'b01,
      ST_LIW_HI = 2'b10,
      ST_LIW_LO = 2'b11
   } seq_state_e;

   // Micro-op as presented to the immediate datapath
   typedef struct packed {
      logic               valid;
      logic [IMM_W-1:0]   instr;
      logic [IMMOP_W-1:0] immop;
      logic               regzero;
      logic               uop_seq;
      logic               illegal;
   } uop_t;

   localparam uop_t UOP_IDLE = '{
      valid:   1'b0,
      instr:   '0,
      immop:   IMMOP_IMM7,
      regzero: 1'b1,
      uop_seq: 1'b0,
      illegal: 1'b0
   };

   function automatic op_class_e op_class(input logic [OPC_W-1:0] opcode);
      return op_class_e'(opcode[OPC_W-1 -: CLASS_W]);
   endfunction

endpackage

// File: rtl/imm_class_decode.sv
// Combinational opcode-class decode into immediate-generator controls.
module imm_class_decode
   import imm_issue_sequencer_pkg::*;
(
   input  logic [OPC_W-1:0]   opcode,
   output logic [IMMOP_W-1:0] immop,
   output logic               regzero,
   output logic               is_liw,
   output logic               is_illegal
);

   op_class_e cls;

   assign cls = op_class(opcode);

   always_comb begin
      immop      = IMMOP_IMM7;
      regzero    = 1'b0;
      is_liw     = 1'b0;
      is_illegal = 1'b0;
      case (cls)
         CLS_RTYPE:  regzero = 1'b1;
         CLS_IMM7:   immop   = IMMOP_IMM7;
         CLS_IMM9:   immop   = IMMOP_IMM9;
         CLS_BRANCH: immop   = IMMOP_IMM7_SH1;
         CLS_JUMP:   immop   = IMMOP_IMM9_SH1;
         CLS_LUI:    immop   = IMMOP_IMM_SH7;
         // First LIW micro-op carries the upper part
         CLS_LIW: begin
            immop  = IMMOP_IMM_SH7;
            is_liw = 1'b1;
         end
         CLS_RSVD: begin
            regzero    = 1'b1;
            is_illegal = 1'b1;
         end
         default: regzero = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_issue_sequencer.sv
// One-deep issue sequencer feeding the immediate generator; splits LIW
// instructions into two micro-ops and flags reserved opcodes.
module imm_issue_sequencer
   import imm_issue_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IMM_W-1:0]   out_instr,
   output logic [IMMOP_W-1:0] ImmOp,
   output logic               RegZero,
   output logic               uop_seq,
   output logic               illegal
);

   seq_state_e         state_q;
   seq_state_e         state_nxt;
   uop_t               uop_q;
   uop_t               uop_nxt;
   logic               accept;
   logic               issue;
   logic               load;
   logic [IMMOP_W-1:0] dec_immop;
   logic               dec_regzero;
   logic               dec_is_liw;
   logic               dec_is_illegal;

   imm_class_decode u_decode (
      .opcode     (in_instr[INSTR_W-1 -: OPC_W]),
      .immop      (dec_immop),
      .regzero    (dec_regzero),
      .is_liw     (dec_is_liw),
      .is_illegal (dec_is_illegal)
   );

   // A slot frees up only when the current (last) micro-op leaves this cycle
   assign in_ready = rst_n && !flush &&
                     ((state_q == ST_EMPTY) ||
                      (((state_q == ST_FULL) || (state_q == ST_LIW_LO)) && out_ready));

   assign accept = in_valid && in_ready;
   assign issue  = uop_q.valid && out_ready;

   // Next-state and next micro-op; outputs hold unless a transfer happens
   always_comb begin
      state_nxt       = state_q;
      uop_nxt         = uop_q;
      uop_nxt.illegal = 1'b0;
      load            = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
         uop_nxt   = UOP_IDLE;
      end else begin
         case (state_q)
            ST_EMPTY: load = accept;
            ST_FULL, ST_LIW_LO: begin
               if (issue) begin
                  if (accept) begin
                     load = 1'b1;
                  end else begin
                     state_nxt = ST_EMPTY;
                     uop_nxt   = UOP_IDLE;
                  end
               end
            end
            ST_LIW_HI: begin
               if (issue) begin
                  state_nxt       = ST_LIW_LO;
                  uop_nxt.immop   = IMMOP_IMM7;
                  uop_nxt.regzero = 1'b0;
                  uop_nxt.uop_seq = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               uop_nxt   = UOP_IDLE;
            end
         endcase
         if (load) begin
            state_nxt = dec_is_liw ? ST_LIW_HI : ST_FULL;
            uop_nxt   = '{
               valid:   1'b1,
               instr:   in_instr[IMM_W-1:0],
               immop:   dec_immop,
               regzero: dec_regzero,
               uop_seq: 1'b0,
               illegal: dec_is_illegal
            };
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         uop_q   <= UOP_IDLE;
      end else begin
         state_q <= state_nxt;
         uop_q   <= uop_nxt;
      end
   end

   assign out_valid = uop_q.valid;
   assign out_instr = uop_q.instr;
   assign ImmOp     = uop_q.immop;
   assign RegZero   = uop_q.regzero;
   assign uop_seq   = uop_q.uop_seq;
   assign illegal   = uop_q.illegal;

endmodule

// File: tb/tb_imm_issue_sequencer.sv
// Scoreboard bench for imm_issue_sequencer: expected micro-ops are queued at
// accept time and popped by a monitor as each issue is observed.
module tb_imm_issue_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_instr;
   logic [2:0]  ImmOp;
   logic        RegZero;
   logic        uop_seq;
   logic        illegal;

   typedef struct packed {
      logic [10:0] instr;
      logic [2:0]  immop;
      logic        regzero;
      logic        seq;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   imm_issue_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_instr  (in_instr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .ImmOp     (ImmOp),
      .RegZero   (RegZero),
      .uop_seq   (uop_seq),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Reference decode table: queue the micro-op(s) an accepted instruction must produce
   task automatic push_expect(input logic [15:0] instr);
      logic [2:0] cls;
      cls = instr[15:13];
      case (cls)
         3'b000: sb.push_back('{instr[10:0], 3'b000, 1'b1, 1'b0});
         3'b001: sb.push_back('{instr[10:0], 3'b000, 1'b0, 1'b0});
         3'b010: sb.push_back('{instr[10:0], 3'b001, 1'b0, 1'b0});
         3'b011: sb.push_back('{instr[10:0], 3'b010, 1'b0, 1'b0});
         3'b100: sb.push_back('{instr[10:0], 3'b011, 1'b0, 1'b0});
         3'b101: sb.push_back('{instr[10:0], 3'b101, 1'b0, 1'b0});
         3'b110: begin
            sb.push_back('{instr[10:0], 3'b101, 1'b0, 1'b0});
            sb.push_back('{instr[10:0], 3'b000, 1'b0, 1'b1});
         end
         default: sb.push_back('{instr[10:0], 3'b000, 1'b1, 1'b0});
      endcase
   endtask

   // Issue monitor: every consumed micro-op must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got instr=%h immop=%b seq=%b, required no issue",
                     out_instr, ImmOp, uop_seq);
         end else begin
            mon_e = sb.pop_front();
            if ({out_instr, ImmOp, RegZero, uop_seq} !== mon_e) begin
               n_fail++;
               $display("FAIL issue_uop: got instr=%h immop=%b rz=%b seq=%b, required instr=%h immop=%b rz=%b seq=%b",
                        out_instr, ImmOp, RegZero, uop_seq,
                        mon_e.instr, mon_e.immop, mon_e.regzero, mon_e.seq);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_instr = 16'h4123; out_ready = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      n_checks++;
      if ({out_valid, out_instr, ImmOp, RegZero, uop_seq, illegal} !== {1'b0, 11'h000, 3'b000, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b instr=%h immop=%b rz=%b seq=%b ill=%b, required 0/000/000/1/0/0",
                  out_valid, out_instr, ImmOp, RegZero, uop_seq, illegal);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_instr = 16'h4123; out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b required 1", in_ready); end
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ImmOp, RegZero, uop_seq} !== {1'b1, 3'b001, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_present: got v=%b immop=%b rz=%b seq=%b, required 1/001/0/0", out_valid, ImmOp, RegZero, uop_seq);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ImmOp, RegZero} !== {1'b0, 3'b000, 1'b1}) begin
         n_fail++;
         $display("FAIL single_idle: got v=%b immop=%b rz=%b, required 0/000/1", out_valid, ImmOp, RegZero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_liw();
      in_valid = 1'b1; in_instr = 16'hC0FF; out_ready = 1'b1;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_instr = 16'h2005;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL liw_hi_in_ready: got %b required 0", in_ready); end
      n_checks++;
      if ({out_valid, ImmOp, uop_seq} !== {1'b1, 3'b101, 1'b0}) begin
         n_fail++;
         $display("FAIL liw_hi_uop: got v=%b immop=%b seq=%b, required 1/101/0", out_valid, ImmOp, uop_seq);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ImmOp, uop_seq, in_ready} !== {1'b1, 3'b000, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL liw_lo_uop: got v=%b immop=%b seq=%b in_ready=%b, required 1/000/1/1",
                  out_valid, ImmOp, uop_seq, in_ready);
      end
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_instr, uop_seq} !== {1'b1, 11'h005, 1'b0}) begin
         n_fail++;
         $display("FAIL liw_reload: got v=%b instr=%h seq=%b, required 1/005/0", out_valid, out_instr, uop_seq);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_instr = 16'h2005; out_ready = 1'b1;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_instr = 16'h6010;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ImmOp, in_ready} !== {1'b1, 3'b000, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_first: got v=%b immop=%b in_ready=%b, required 1/000/1", out_valid, ImmOp, in_ready);
      end
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ImmOp} !== {1'b1, 3'b010}) begin
         n_fail++;
         $display("FAIL b2b_second: got v=%b immop=%b, required 1/010", out_valid, ImmOp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got v=%b required 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      in_valid = 1'b1; in_instr = 16'h8001; out_ready = 1'b0;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_instr = 16'h2005;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, out_instr, ImmOp, RegZero, in_ready} !== {1'b1, 11'h001, 3'b011, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b instr=%h immop=%b rz=%b in_ready=%b, required 1/001/011/0/0",
                     i, out_valid, out_instr, ImmOp, RegZero, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got v=%b required 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_instr = 16'hC0FF; out_ready = 1'b1;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      void'(sb.pop_front());
      void'(sb.pop_front());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, ImmOp, RegZero, uop_seq} !== {1'b0, 3'b000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_idle[%0d]: got v=%b immop=%b rz=%b seq=%b, required 0/000/1/0",
                     i, out_valid, ImmOp, RegZero, uop_seq);
         end
         @(posedge clk); #1;
      end
      flush = 1'b1; in_valid = 1'b1; in_instr = 16'h4123;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_empty_in_ready: got %b required 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ignore_instr: got v=%b required 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_illegal_reset();
      in_valid = 1'b1; in_instr = 16'hF800; out_ready = 1'b0;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({illegal, out_valid, ImmOp, RegZero} !== {1'b1, 1'b1, 3'b000, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_first: got ill=%b v=%b immop=%b rz=%b, required 1/1/000/1", illegal, out_valid, ImmOp, RegZero);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({illegal, out_valid} !== {1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_stall: got ill=%b v=%b, required 0/1", illegal, out_valid);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = 16'hC0FF;
      @(negedge clk);
      push_expect(in_instr);
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      @(posedge clk); #1;
      void'(sb.pop_front());
      void'(sb.pop_front());
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_instr, ImmOp, RegZero, uop_seq, illegal} !== {1'b0, 11'h000, 3'b000, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid_liw: got v=%b instr=%h immop=%b rz=%b seq=%b ill=%b, required 0/000/000/1/0/0",
                  out_valid, out_instr, ImmOp, RegZero, uop_seq, illegal);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: got v=%b required 0", out_valid); end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_liw();
      test_back_to_back();
      test_stall();
      test_flush();
      test_illegal_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending micro-ops, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
